// File: rtl/cc_uart_rx_pkg.sv
// Shared UART definitions: receiver state encoding, 8N1 data width and the
// 3-sample majority helper used to decide each bit.
package cc_uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/cc_baud_tick.sv
// Oversample tick generator: a one-cycle enable every DIV clocks, free-running,
// realigned by restart so a frame's ticks are phased from its start edge.
module cc_baud_tick #(
  parameter int CLK_FREQ   = 30_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == CNT_LAST) && !restart;

endmodule

// File: rtl/cc_uart_rx.sv
// UART 8N1 receiver: 2-FF synchroniser, oversampled 3-sample majority vote,
// false-start rejection and break recovery via WAIT_IDLE.
module cc_uart_rx
  import cc_uart_rx_pkg::*;
#(
  parameter int CLK_FREQ   = 30_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_valid,
  output rx_state_e            state_dbg
);

  localparam int MID = OVERSAMPLE / 2;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_S0   = TW'(MID - 1);
  localparam logic [TW-1:0] T_S1   = TW'(MID);
  localparam logic [TW-1:0] T_DEC  = TW'(MID + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

  logic                 rx_meta;
  logic                 rx_s;
  rx_state_e            state;
  logic [TW-1:0]        tick_cnt;
  logic [TW-1:0]        tick_nxt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 s0;
  logic                 s1;
  logic                 restart;
  logic                 tick;
  logic                 decide;
  logic                 vote;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  assign restart = (state == IDLE) && !rx_s;

  cc_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  assign tick_nxt = (tick_cnt == T_LAST) ? '0 : tick_cnt + TW'(1);
  assign decide   = tick && (tick_nxt == T_DEC);
  assign vote     = maj3(s0, s1, rx_s);

  // rx_done pulses for one clock at every frame end; rx_data/rx_valid change
  // in that same cycle, so a consumer may latch them on rx_done alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      s0        <= 1'b1;
      s1        <= 1'b1;
      rx_data   <= '0;
      rx_done   <= 1'b0;
      rx_valid  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      if (tick && (tick_nxt == T_S0)) s0 <= rx_s;
      if (tick && (tick_nxt == T_S1)) s1 <= rx_s;

      case (state)
        WAIT_IDLE: begin
          // tick_cnt doubles as the run length of consecutive high ticks
          if (!rx_s) begin
            tick_cnt <= '0;
          end else if (tick) begin
            if (tick_cnt == T_LAST) begin
              state    <= IDLE;
              tick_cnt <= '0;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        IDLE: begin
          // The detected edge counts as the first tick of the start bit
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= TW'(1);
            rx_valid <= 1'b0;
          end
        end

        START: begin
          if (tick) begin
            tick_cnt <= tick_nxt;
            if (decide) begin
              if (vote) begin
                state <= IDLE;
              end else begin
                state   <= DATA;
                bit_idx <= '0;
              end
            end
          end
        end

        DATA: begin
          if (tick) begin
            tick_cnt <= tick_nxt;
            if (decide) begin
              shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
              if (bit_idx == 3'd7) begin
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end
          end
        end

        STOP: begin
          if (tick) begin
            tick_cnt <= tick_nxt;
            if (decide) begin
              rx_done <= 1'b1;
              if (vote) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
                state    <= IDLE;
              end else begin
                rx_valid <= 1'b0;
                state    <= WAIT_IDLE;
                tick_cnt <= '0;
              end
            end
          end
        end

        default: begin
          state    <= WAIT_IDLE;
          tick_cnt <= '0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_cc_uart_rx.sv
// Directed bench for cc_uart_rx at DIV=16, OVERSAMPLE=16 (256 clk per bit).
`timescale 1ns/1ps
module tb_cc_uart_rx;
  import cc_uart_rx_pkg::*;

  localparam int CLK_NS = 10;
  localparam int BIT_NS = 256 * CLK_NS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_valid;
  rx_state_e  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int spurious = 0;
  int run_len  = 0;
  int max_run  = 0;

  // clock / reset
  always #(CLK_NS / 2) clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cc_uart_rx #(
    .CLK_FREQ  (29_491_200),
    .BAUD      (115_200),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_valid (rx_valid),
    .state_dbg(state_dbg)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: every rx_done pops one expected {rx_valid, rx_data}
  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() > 0) check_eq("frame", {23'd0, rx_valid, rx_data}, {23'd0, exp_q.pop_front()});
      else spurious++;
    end else begin
      run_len = 0;
    end
  end

  // driver tasks
  task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_ns);
    rx_in = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      #(bit_ns);
    end
    rx_in = stop;
    #(bit_ns);
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {31'd0, done_cnt >= target}, 32'd1);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t0;
    int lat;

    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("rst_data",  rx_data,   8'h00);
    check_eq("rst_done",  rx_done,   1'b0);
    check_eq("rst_valid", rx_valid,  1'b0);
    check_eq("rst_state", state_dbg, WAIT_IDLE);
    rst = 1'b0;
    idle(300);
    check_eq("idle_state", state_dbg, IDLE);

    // 0xA5 with latency
    base = done_cnt;
    exp_q.push_back({1'b1, 8'hA5});
    t0 = cyc;
    fork
      send_frame(8'hA5, 1'b1, BIT_NS);
      wait_done("a5_done", base + 1, 3000);
    join
    lat = done_cyc - t0;
    check_eq($sformatf("a5_latency_%0d_in_2432_2436", lat), {31'd0, (lat >= 2432) && (lat <= 2436)}, 32'd1);
    check_eq("a5_data",  rx_data,  8'hA5);
    check_eq("a5_valid", rx_valid, 1'b1);
    idle(50);

    // 40-clk glitch then 0x5A
    base = done_cnt;
    rx_in = 1'b0;
    repeat (40) @(negedge clk);
    idle(400);
    check_eq("glitch_no_done", done_cnt, base);
    check_eq("glitch_state", state_dbg, IDLE);
    exp_q.push_back({1'b1, 8'h5A});
    fork
      send_frame(8'h5A, 1'b1, BIT_NS);
      wait_done("5a_done", base + 1, 3000);
    join
    check_eq("5a_data", rx_data, 8'h5A);
    idle(50);

    // 0x3C with a low stop bit, line held low 2000 clk from the stop bit
    base = done_cnt;
    exp_q.push_back({1'b0, 8'h5A});
    fork
      begin
        send_frame(8'h3C, 1'b0, BIT_NS);
        #(1744 * CLK_NS);
      end
      wait_done("brk_done", base + 1, 3000);
    join
    check_eq("brk_valid", rx_valid, 1'b0);
    check_eq("brk_data", rx_data, 8'h5A);
    check_eq("brk_single_done", done_cnt, base + 1);
    check_eq("brk_state", state_dbg, WAIT_IDLE);
    idle(320);
    check_eq("brk_recover_state", state_dbg, IDLE);
    base = done_cnt;
    exp_q.push_back({1'b1, 8'h55});
    fork
      send_frame(8'h55, 1'b1, BIT_NS);
      wait_done("55_done", base + 1, 3000);
    join
    check_eq("55_valid", rx_valid, 1'b1);
    idle(50);

    // back-to-back 0x00, 0xFF
    base = done_cnt;
    exp_q.push_back({1'b1, 8'h00});
    exp_q.push_back({1'b1, 8'hFF});
    fork
      begin
        send_frame(8'h00, 1'b1, BIT_NS);
        send_frame(8'hFF, 1'b1, BIT_NS);
      end
      wait_done("b2b_done", base + 2, 6000);
    join
    check_eq("b2b_data", rx_data, 8'hFF);
    check_eq("b2b_valid", rx_valid, 1'b1);
    idle(50);

    // reset during bit 3 of 0x00
    base = done_cnt;
    fork
      send_frame(8'h00, 1'b1, BIT_NS);
      begin
        #(BIT_NS * 4 + BIT_NS / 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_done",  rx_done,   1'b0);
        check_eq("midrst_valid", rx_valid,  1'b0);
        check_eq("midrst_data",  rx_data,   8'h00);
        check_eq("midrst_state", state_dbg, WAIT_IDLE);
      end
    join
    idle(300);
    check_eq("midrst_no_done", done_cnt, base);
    check_eq("midrst_idle", state_dbg, IDLE);
    exp_q.push_back({1'b1, 8'hC3});
    fork
      send_frame(8'hC3, 1'b1, BIT_NS);
      wait_done("c3_done", base + 1, 3000);
    join
    check_eq("c3_data", rx_data, 8'hC3);
    idle(50);

    // sender 2.5% fast, then 2.5% slow
    base = done_cnt;
    exp_q.push_back({1'b1, 8'h96});
    fork
      send_frame(8'h96, 1'b1, 2496);
      wait_done("fast_done", base + 1, 3000);
    join
    @(negedge clk);
    check_eq("fast_data", rx_data, 8'h96);
    check_eq("fast_valid", rx_valid, 1'b1);
    idle(50);
    base = done_cnt;
    exp_q.push_back({1'b1, 8'h96});
    fork
      send_frame(8'h96, 1'b1, 2624);
      wait_done("slow_done", base + 1, 3000);
    join
    @(negedge clk);
    check_eq("slow_data", rx_data, 8'h96);
    check_eq("slow_valid", rx_valid, 1'b1);
    idle(50);

    // final report
    check_eq("spurious_done", spurious, 0);
    check_eq("exp_q_left", exp_q.size(), 0);
    check_eq("done_width", max_run, 1);
    check_eq("done_total", done_cnt, 9);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
